// File: rtl/drum_column.sv
// drum_column: time-steps one column of ROWS drum nodes through a single shared
// finite-difference datapath. Current and previous displacements live in two
// ping-pong banks; each step overwrites u_prev with u_next in place and then
// swaps the bank roles.
module drum_column #(
  parameter int                       ROWS    = 32,
  parameter int                       DATA_W  = 18,
  parameter int                       FRAC    = 17,
  parameter logic signed [DATA_W-1:0] RHO_MAX = 18'h0FAE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     init_we,
  input  logic [$clog2(ROWS)-1:0]  init_addr,
  input  logic signed [DATA_W-1:0] init_cur,
  input  logic signed [DATA_W-1:0] init_prev,
  input  logic signed [DATA_W-1:0] rho,
  input  logic signed [DATA_W-1:0] g_tension,
  input  logic signed [DATA_W-1:0] eta_term,
  input  logic                     nonlinear_en,
  output logic [$clog2(ROWS)-1:0]  row_addr,
  input  logic signed [DATA_W-1:0] left_in,
  input  logic signed [DATA_W-1:0] right_in,
  output logic signed [DATA_W-1:0] node_out,
  output logic                     node_valid,
  output logic signed [DATA_W-1:0] center_out,
  output logic                     busy,
  output logic                     done
);

  localparam int            AW       = $clog2(ROWS);
  localparam int            LW       = DATA_W + 3;
  localparam int            MW       = DATA_W + 4;
  localparam logic [AW:0]   ROWS_N   = (AW+1)'(ROWS);
  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam logic [AW-1:0] CTR_ROW  = AW'(ROWS / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME0,
    S_PRIME1,
    S_CALC_A,
    S_CALC_B,
    S_DONE
  } state_t;

  // Fixed-point multiply: full product, arithmetic shift (floor), no saturation.
  function automatic logic signed [MW-1:0] fxmul(input logic signed [MW-1:0] a,
                                                 input logic signed [MW-1:0] b);
    logic signed [2*MW-1:0] p;
    p = (2*MW)'(a) * (2*MW)'(b);
    fxmul = MW'(p >>> FRAC);
  endfunction

  // Clamp the wide update back into the signed node word range.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [MW-1:0] v);
    logic [MW-DATA_W:0] top;
    top = v[MW-1:DATA_W-1];
    if (top == '0 || top == '1) sat = v[DATA_W-1:0];
    else if (v[MW-1])           sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                        sat = {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  state_t                    r_state, w_next;
  logic                      r_sel;
  logic [AW-1:0]             r_row;
  logic signed [DATA_W-1:0]  r_center;

  logic signed [DATA_W-1:0]  r_bank0 [ROWS];
  logic signed [DATA_W-1:0]  r_bank1 [ROWS];

  logic signed [DATA_W-1:0]  r_w0, r_w1, r_w2;
  logic signed [DATA_W-1:0]  r_cur_rd, r_prev_rd;
  logic signed [DATA_W-1:0]  r_eta;
  logic signed [MW-1:0]      r_rho_eff;

  logic [AW:0]               w_cur_idx;
  logic signed [DATA_W-1:0]  w_cur_word, w_prev_word;
  logic signed [MW-1:0]      w_cc, w_gt, w_rsum, w_rho_eff;
  logic signed [LW-1:0]      w_lap;
  logic signed [DATA_W:0]    w_diff;
  logic signed [MW-1:0]      w_eta_t, w_rho_t, w_sum;
  logic signed [DATA_W-1:0]  w_unext;
  logic                      w_start, w_init_ok, w_last;

  assign w_start    = (r_state == S_IDLE) && start;
  assign w_init_ok  = (r_state == S_IDLE) && init_we && ({1'b0, init_addr} < ROWS_N);
  assign w_last     = (r_row == LAST_ROW);
  assign row_addr   = r_row;
  assign center_out = r_center;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and the state-derived outputs.
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    node_valid = 1'b0;
    node_out   = '0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_PRIME0;
      S_PRIME0: begin busy = 1'b1; w_next = S_PRIME1; end
      S_PRIME1: begin busy = 1'b1; w_next = S_CALC_A; end
      S_CALC_A: begin busy = 1'b1; w_next = S_CALC_B; end
      S_CALC_B: begin
        busy       = 1'b1;
        node_valid = 1'b1;
        node_out   = w_unext;
        w_next     = w_last ? S_DONE : S_CALC_A;
      end
      S_DONE:   begin done = 1'b1; w_next = S_IDLE; end
      default:  w_next = S_IDLE;
    endcase
  end

  // Control registers: bank select, row counter, center tap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel    <= 1'b0;
      r_row    <= '0;
      r_center <= '0;
    end else begin
      if (r_state == S_DONE) r_sel <= ~r_sel;
      if (w_start) r_row <= '0;
      else if (r_state == S_CALC_B && !w_last) r_row <= r_row + 1'b1;
      if (r_state == S_CALC_B && r_row == CTR_ROW) r_center <= w_unext;
    end
  end

  // Bank read mux: prime fetches rows 0/1, phase A fetches row r+2 (zero past the end).
  always_comb begin
    case (r_state)
      S_PRIME0: w_cur_idx = '0;
      S_PRIME1: w_cur_idx = (AW+1)'(1);
      default:  w_cur_idx = {1'b0, r_row} + (AW+1)'(2);
    endcase
    w_cur_word = '0;
    if (w_cur_idx < ROWS_N)
      w_cur_word = r_sel ? r_bank1[w_cur_idx[AW-1:0]] : r_bank0[w_cur_idx[AW-1:0]];
    w_prev_word = r_sel ? r_bank0[r_row] : r_bank1[r_row];
  end

  // Bank writes: host init into both banks in IDLE, u_next over u_prev in phase B.
  always_ff @(posedge clk) begin
    if (w_init_ok) begin
      if (r_sel) begin
        r_bank1[init_addr] <= init_cur;
        r_bank0[init_addr] <= init_prev;
      end else begin
        r_bank0[init_addr] <= init_cur;
        r_bank1[init_addr] <= init_prev;
      end
    end else if (r_state == S_CALC_B) begin
      if (r_sel) r_bank0[r_row] <= w_unext;
      else       r_bank1[r_row] <= w_unext;
    end
  end

  // Effective tension, evaluated from the center tap of the previous step.
  always_comb begin
    w_cc   = fxmul(MW'(r_center), MW'(r_center));
    w_gt   = fxmul(MW'(g_tension), w_cc);
    w_rsum = MW'(rho) + w_gt;
    if (!nonlinear_en)              w_rho_eff = MW'(rho);
    else if (w_rsum > MW'(RHO_MAX)) w_rho_eff = MW'(RHO_MAX);
    else                            w_rho_eff = w_rsum;
  end

  // Datapath registers: coefficient capture, read latches and the 3-row window.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_w0      <= '0;
      r_w1      <= '0;
      r_w2      <= '0;
      r_eta     <= eta_term;
      r_rho_eff <= w_rho_eff;
    end
    if (r_state == S_PRIME1 || r_state == S_CALC_A) begin
      r_w0 <= r_w1;
      r_w1 <= r_w2;
      r_w2 <= r_cur_rd;
    end
    if (r_state == S_PRIME0 || r_state == S_PRIME1 || r_state == S_CALC_A)
      r_cur_rd <= w_cur_word;
    if (r_state == S_CALC_A)
      r_prev_rd <= w_prev_word;
  end

  // Phase-B update: laplacian, damping and tension terms, then saturation.
  always_comb begin
    w_lap   = LW'(r_w0) + LW'(r_w2) + LW'(left_in) + LW'(right_in) - (LW'(r_w1) <<< 2);
    w_diff  = (DATA_W+1)'(r_w1) - (DATA_W+1)'(r_prev_rd);
    w_eta_t = fxmul(MW'(r_eta), MW'(w_diff));
    w_rho_t = fxmul(r_rho_eff, MW'(w_lap));
    w_sum   = MW'(r_w1) + MW'(w_diff) - w_eta_t + w_rho_t;
    w_unext = sat(w_sum);
  end

endmodule

// File: tb/tb_drum_column.sv
// Directed bench for drum_column at ROWS=4: a vector table of whole steps with
// hand-computed node values, plus back-to-back, busy-ignore and mid-step reset sequences.
module tb_drum_column;

  localparam int ROWS = 4;
  localparam int DW   = 18;
  localparam int AW   = 2;
  localparam int NV   = 8;

  typedef logic [DW-1:0] word_t;
  localparam word_t Z = '0;

  typedef struct {
    logic                     init;
    logic [ROWS-1:0][DW-1:0]  cur;
    logic [ROWS-1:0][DW-1:0]  prv;
    word_t                    rho;
    word_t                    eta;
    word_t                    g;
    word_t                    nb;
    logic                     nl;
    logic [ROWS-1:0][DW-1:0]  exp;
    word_t                    ctr;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset, start, init_we, nonlinear_en;
  logic [AW-1:0]        init_addr, row_addr;
  logic signed [DW-1:0] init_cur, init_prev, rho, g_tension, eta_term, left_in, right_in;
  logic signed [DW-1:0] node_out, center_out;
  logic                 node_valid, busy, done;

  drum_column #(.ROWS(ROWS), .DATA_W(DW), .FRAC(17), .RHO_MAX(18'h0FAE1)) dut (
    .clk(clk), .reset(reset), .start(start), .init_we(init_we),
    .init_addr(init_addr), .init_cur(init_cur), .init_prev(init_prev),
    .rho(rho), .g_tension(g_tension), .eta_term(eta_term), .nonlinear_en(nonlinear_en),
    .row_addr(row_addr), .left_in(left_in), .right_in(right_in),
    .node_out(node_out), .node_valid(node_valid), .center_out(center_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  vec_t  vecs [NV];
  word_t cap [ROWS];
  int    vld_edge [ROWS];
  int    nv_cnt, done_edge, ra_bad;
  logic  busy1, busy_at_done;
  word_t ctr_at_done;

  task automatic check_w(input string name, input word_t got, input word_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_b(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic check_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic ini,
                              input word_t c0, c1, c2, c3, p0, p1, p2, p3,
                              input word_t r, et, g, nb, input logic nl,
                              input word_t e0, e1, e2, e3, ct);
    vec_t v;
    v.init = ini;
    v.cur  = {c3, c2, c1, c0};
    v.prv  = {p3, p2, p1, p0};
    v.rho  = r;
    v.eta  = et;
    v.g    = g;
    v.nb   = nb;
    v.nl   = nl;
    v.exp  = {e3, e2, e1, e0};
    v.ctr  = ct;
    return v;
  endfunction

  task automatic write_init(input int a, input word_t c, input word_t p);
    @(negedge clk);
    init_we   = 1'b1;
    init_addr = AW'(a);
    init_cur  = c;
    init_prev = p;
    @(posedge clk);
    #1 init_we = 1'b0;
  endtask

  // Caller raises start at a negedge; this walks the step and records what it sees.
  task automatic run_step(input logic hold);
    nv_cnt = 0; done_edge = -1; ra_bad = 0; busy1 = 1'b0; busy_at_done = 1'b1; ctr_at_done = Z;
    for (int i = 0; i < ROWS; i++) begin cap[i] = Z; vld_edge[i] = -1; end
    @(posedge clk);
    @(negedge clk);
    start   = hold;
    init_we = 1'b0;
    for (int e = 1; e <= 3 * ROWS + 10; e++) begin
      if (e == 1) busy1 = busy;
      if (node_valid) begin
        if (nv_cnt < ROWS) begin
          cap[nv_cnt]      = node_out;
          vld_edge[nv_cnt] = e;
          if (row_addr != AW'(nv_cnt)) ra_bad++;
        end
        nv_cnt++;
      end
      if (done) begin
        done_edge    = e;
        busy_at_done = busy;
        ctr_at_done  = center_out;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int dn;
    int e2;
    reset = 1'b1; start = 1'b0; init_we = 1'b0; init_addr = '0; init_cur = Z; init_prev = Z;
    rho = Z; g_tension = Z; eta_term = Z; nonlinear_en = 1'b0; left_in = Z; right_in = Z;

    vecs[0] = mk(1'b1, Z, Z, Z, Z, Z, Z, Z, Z, 18'h02000, Z, Z, Z, 1'b0, Z, Z, Z, Z, Z);
    vecs[1] = mk(1'b1, Z, 18'h04000, Z, Z, Z, 18'h04000, Z, Z, 18'h02000, Z, Z, Z, 1'b0,
                 18'h00400, 18'h03000, 18'h00400, Z, 18'h00400);
    vecs[2] = mk(1'b0, Z, Z, Z, Z, Z, Z, Z, Z, 18'h02000, Z, Z, Z, 1'b0,
                 18'h00A00, 18'h01480, 18'h00A00, 18'h00040, 18'h00A00);
    vecs[3] = mk(1'b1, Z, Z, 18'h1FFFF, Z, Z, Z, 18'h20000, Z, Z, Z, Z, Z, 1'b0,
                 Z, Z, 18'h1FFFF, Z, 18'h1FFFF);
    vecs[4] = mk(1'b0, Z, Z, Z, Z, Z, Z, Z, Z, 18'h02000, Z, 18'h1FFFF, Z, 1'b1,
                 Z, 18'h0FAE0, 18'h2147C, 18'h0FAE0, 18'h2147C);
    vecs[5] = mk(1'b1, Z, Z, 18'h20000, Z, Z, Z, 18'h1FFFF, Z, Z, Z, Z, Z, 1'b0,
                 Z, Z, 18'h20000, Z, 18'h20000);
    vecs[6] = mk(1'b1, Z, Z, Z, Z, Z, Z, Z, Z, 18'h02000, Z, Z, 18'h01000, 1'b0,
                 18'h00200, 18'h00200, 18'h00200, 18'h00200, 18'h00200);
    vecs[7] = mk(1'b1, 18'h04000, Z, Z, Z, Z, Z, Z, Z, Z, 18'h10000, Z, Z, 1'b0,
                 18'h06000, Z, Z, Z, Z);

    repeat (3) @(negedge clk);
    check_b("reset busy", busy, 1'b0);
    check_b("reset done", done, 1'b0);
    check_b("reset node_valid", node_valid, 1'b0);
    check_w("reset node_out", node_out, Z);
    check_w("reset center_out", center_out, Z);
    check_w("reset row_addr", word_t'(row_addr), Z);
    reset = 1'b0;

    for (int v = 0; v < NV; v++) begin
      if (vecs[v].init)
        for (int i = 0; i < ROWS; i++) write_init(i, vecs[v].cur[i], vecs[v].prv[i]);
      @(negedge clk);
      rho = vecs[v].rho; eta_term = vecs[v].eta; g_tension = vecs[v].g;
      left_in = vecs[v].nb; right_in = vecs[v].nb; nonlinear_en = vecs[v].nl;
      start = 1'b1;
      run_step(1'b0);
      for (int i = 0; i < ROWS; i++)
        check_w($sformatf("v%0d row%0d node_out", v, i), cap[i], vecs[v].exp[i]);
      check_i($sformatf("v%0d node_valid count", v), nv_cnt, ROWS);
      check_i($sformatf("v%0d done edge", v), done_edge, 2 * ROWS + 3);
      check_i($sformatf("v%0d row_addr at valid", v), ra_bad, 0);
      check_w($sformatf("v%0d center_out", v), ctr_at_done, vecs[v].ctr);
      check_b($sformatf("v%0d busy at done", v), busy_at_done, 1'b0);
      if (v == 0) begin
        check_b("busy at edge 1", busy1, 1'b1);
        for (int i = 0; i < ROWS; i++)
          check_i($sformatf("valid edge row%0d", i), vld_edge[i], 4 + 2 * i);
      end
    end

    // Held start: first step unaffected, next step begins at edge 2*ROWS+4.
    left_in = Z; right_in = Z;
    for (int i = 0; i < ROWS; i++) write_init(i, Z, Z);
    @(negedge clk);
    rho = 18'h02000; eta_term = Z; g_tension = Z; nonlinear_en = 1'b0; start = 1'b1;
    run_step(1'b1);
    check_i("b2b first done edge", done_edge, 2 * ROWS + 3);
    e2 = -1;
    for (int e = 2 * ROWS + 3; e <= 6 * ROWS + 10; e++) begin
      if (e == 2 * ROWS + 8) begin
        init_we = 1'b1; init_addr = AW'(1); init_cur = 18'h04000; init_prev = 18'h04000;
      end else begin
        init_we = 1'b0;
      end
      if (done && e > 2 * ROWS + 3) begin
        e2 = e;
        start = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    init_we = 1'b0;
    check_i("b2b second done edge", e2, 4 * ROWS + 7);
    check_b("b2b busy at second done", busy, 1'b0);
    @(negedge clk);
    start = 1'b1;
    run_step(1'b0);
    for (int i = 0; i < ROWS; i++)
      check_w($sformatf("busy init ignored row%0d", i), cap[i], Z);

    // Reset during a step, then init+start in one cycle.
    write_init(0, Z, Z);
    write_init(1, 18'h04000, 18'h04000);
    write_init(2, Z, Z);
    write_init(3, Z, Z);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_b("busy before mid-step reset", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_b("busy after mid-step reset", busy, 1'b0);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 3 * ROWS + 6; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    check_i("done pulses after reset", dn, 0);
    write_init(0, Z, Z);
    write_init(2, Z, Z);
    write_init(3, Z, Z);
    @(negedge clk);
    init_we = 1'b1; init_addr = AW'(1); init_cur = 18'h04000; init_prev = 18'h04000;
    start = 1'b1;
    run_step(1'b0);
    check_w("post-reset row0", cap[0], 18'h00400);
    check_w("post-reset row1", cap[1], 18'h03000);
    check_w("post-reset row2", cap[2], 18'h00400);
    check_w("post-reset row3", cap[3], Z);
    check_i("post-reset done edge", done_edge, 2 * ROWS + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
